// File: rtl/arb_frame_loader.sv
// arb_frame_loader: packs a serial stream of (score, position) evaluations
// into N_SLOTS registered arbiter slots, pads unused slots with copies of
// slot 0, and holds the completed frame until the consumer acknowledges it.
module arb_frame_loader #(
    parameter int N_SLOTS = 64,
    parameter int SCORE_W = 6,
    parameter int POS_W   = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [SCORE_W-1:0]         s_score,
    input  logic [POS_W-1:0]           s_pos,
    input  logic                       s_last,
    output logic [N_SLOTS*SCORE_W-1:0] slot_score,
    output logic [N_SLOTS*POS_W-1:0]   slot_pos,
    output logic                       frame_valid,
    input  logic                       frame_ack,
    output logic [6:0]                 frame_count,
    output logic                       frame_full
);

    localparam int IDX_W = $clog2(N_SLOTS);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W:0]       count_q, count_d;
    logic                 full_q, full_d;
    logic [SCORE_W-1:0]   slot_score_q [N_SLOTS];
    logic [SCORE_W-1:0]   slot_score_d [N_SLOTS];
    logic [POS_W-1:0]     slot_pos_q   [N_SLOTS];
    logic [POS_W-1:0]     slot_pos_d   [N_SLOTS];
    logic                 accept;

    // Handshake and frame status decode from registered state only; the
    // reset term keeps ready low while reset is being applied.
    assign s_ready     = (state_q == ST_FILL) && !rst;
    assign frame_valid = (state_q == ST_HOLD);
    assign frame_count = count_q;
    assign frame_full  = full_q;
    assign accept      = s_valid && s_ready;

    // Flatten slot registers onto the arbiter input buses.
    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot_out
            assign slot_score[gi*SCORE_W +: SCORE_W] = slot_score_q[gi];
            assign slot_pos[gi*POS_W +: POS_W]       = slot_pos_q[gi];
        end
    endgenerate

    // Next-state logic: fill one slot per accepted entry, pad, then hold.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        count_d      = count_q;
        full_d       = full_q;
        slot_score_d = slot_score_q;
        slot_pos_d   = slot_pos_q;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    slot_score_d[idx_q] = s_score;
                    slot_pos_d[idx_q]   = s_pos;
                    idx_d               = idx_q + IDX_W'(1);
                    count_d             = {1'b0, idx_q} + (IDX_W+1)'(1);
                    if (idx_q == IDX_W'(N_SLOTS-1)) begin
                        // Frame closed by capacity; flag it unless the
                        // producer also marked this entry as last.
                        state_d = ST_HOLD;
                        full_d  = !s_last;
                    end else if (s_last) begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                // Copies of slot 0 can only win a tie with slot 0's own
                // values, so the arbiter result is always a real entry.
                for (int j = 1; j < N_SLOTS; j++) begin
                    if (j >= int'(count_q)) begin
                        slot_score_d[j] = slot_score_q[0];
                        slot_pos_d[j]   = slot_pos_q[0];
                    end
                end
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (frame_ack) begin
                    state_d = ST_FILL;
                    idx_d   = '0;
                    full_d  = 1'b0;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // State and slot registers; reset discards any partial or held frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            for (int k = 0; k < N_SLOTS; k++) begin
                slot_score_q[k] <= '0;
                slot_pos_q[k]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            full_q       <= full_d;
            slot_score_q <= slot_score_d;
            slot_pos_q   <= slot_pos_d;
        end
    end

endmodule

// File: tb/tb_arb_frame_loader.sv
// Directed self-checking bench for arb_frame_loader.
module tb_arb_frame_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [5:0]   s_score;
    logic [5:0]   s_pos;
    logic         s_last;
    logic [383:0] slot_score;
    logic [383:0] slot_pos;
    logic         frame_valid;
    logic         frame_ack;
    logic [6:0]   frame_count;
    logic         frame_full;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] exp_s [64];
    logic [5:0] exp_p [64];

    arb_frame_loader #(.N_SLOTS(64), .SCORE_W(6), .POS_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_score     (s_score),
        .s_pos       (s_pos),
        .s_last      (s_last),
        .slot_score  (slot_score),
        .slot_pos    (slot_pos),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_count (frame_count),
        .frame_full  (frame_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one entry and wait until it is taken at a clock edge; returns
    // one cycle after acceptance.
    task automatic send(input logic [5:0] sc, input logic [5:0] ps, input logic last);
        int w;
        s_valid = 1'b1;
        s_score = sc;
        s_pos   = ps;
        s_last  = last;
        w = 0;
        while (!s_ready && w < 100) begin
            step();
            w++;
        end
        if (!s_ready) check("send_timeout", 384'(s_ready), 384'd1);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        $display("tx score=%0d pos=%0d last=%0d", sc, ps, last);
    endtask

    function automatic logic [383:0] pack_s();
        logic [383:0] r;
        for (int i = 0; i < 64; i++) r[i*6 +: 6] = exp_s[i];
        return r;
    endfunction

    function automatic logic [383:0] pack_p();
        logic [383:0] r;
        for (int i = 0; i < 64; i++) r[i*6 +: 6] = exp_p[i];
        return r;
    endfunction

    // Reference max arbiter over the slot buses; ties go to the higher index.
    task automatic arb(output logic [5:0] bs, output logic [5:0] bp);
        int best;
        best = 0;
        for (int i = 1; i < 64; i++)
            if (slot_score[i*6 +: 6] >= slot_score[best*6 +: 6]) best = i;
        bs = slot_score[best*6 +: 6];
        bp = slot_pos[best*6 +: 6];
    endtask

    task automatic check_frame(input string tag, input int cnt, input logic full,
                               input logic [5:0] a_s, input logic [5:0] a_p);
        logic [5:0] bs, bp;
        check({tag, "_valid"}, 384'(frame_valid), 384'd1);
        check({tag, "_ready"}, 384'(s_ready), 384'd0);
        check({tag, "_count"}, 384'(frame_count), 384'(cnt));
        check({tag, "_full"},  384'(frame_full), 384'(full));
        check({tag, "_score_bus"}, slot_score, pack_s());
        check({tag, "_pos_bus"},   slot_pos, pack_p());
        arb(bs, bp);
        check({tag, "_arb_score"}, 384'(bs), 384'(a_s));
        check({tag, "_arb_pos"},   384'(bp), 384'(a_p));
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        check("ack_valid_low", 384'(frame_valid), 384'd0);
        check("ack_ready_high", 384'(s_ready), 384'd1);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_score = '0; s_pos = '0; s_last = 1'b0; frame_ack = 1'b0;
        step();
        step();
        check("rst_ready", 384'(s_ready), 384'd0);
        check("rst_valid", 384'(frame_valid), 384'd0);
        check("rst_count", 384'(frame_count), 384'd0);
        check("rst_score_bus", slot_score, 384'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 384'(s_ready), 384'd1);

        // Single entry: padded to every slot.
        send(6'd5, 6'd12, 1'b1);
        check("single_pad_valid", 384'(frame_valid), 384'd0);
        check("single_pad_ready", 384'(s_ready), 384'd0);
        step();
        for (int i = 0; i < 64; i++) begin exp_s[i] = 6'd5; exp_p[i] = 6'd12; end
        check_frame("single", 1, 1'b0, 6'd5, 6'd12);
        ack();

        // Full frame closed by s_last on entry 64: no pad cycle.
        for (int i = 0; i < 64; i++) begin
            exp_s[i] = 6'(i % 50);
            exp_p[i] = 6'(i);
            send(exp_s[i], exp_p[i], i == 63);
        end
        check_frame("full64", 64, 1'b0, 6'd49, 6'd49);
        ack();

        // Overflow: 64 entries without s_last, 65th held until ack.
        for (int i = 0; i < 64; i++) begin
            exp_s[i] = 6'(i);
            exp_p[i] = 6'(63 - i);
            send(exp_s[i], exp_p[i], 1'b0);
        end
        check_frame("ovf", 64, 1'b1, 6'd63, 6'd0);
        s_valid = 1'b1; s_score = 6'd33; s_pos = 6'd44; s_last = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("ovf_hold_ready", 384'(s_ready), 384'd0);
            check("ovf_hold_slot0", 384'(slot_score[5:0]), 384'd0);
        end
        ack();
        step();
        s_valid = 1'b0;
        $display("tx score=33 pos=44 last=0");
        send(6'd1, 6'd2, 1'b1);
        step();
        for (int i = 0; i < 64; i++) begin exp_s[i] = 6'd33; exp_p[i] = 6'd44; end
        exp_s[1] = 6'd1; exp_p[1] = 6'd2;
        check_frame("ovf_next", 2, 1'b0, 6'd33, 6'd44);
        ack();

        // Padding tie: winner is the highest-index copy of slot 0.
        send(6'd0, 6'd7, 1'b0);
        send(6'd0, 6'd9, 1'b0);
        send(6'd0, 6'd20, 1'b1);
        step();
        for (int i = 0; i < 64; i++) begin exp_s[i] = 6'd0; exp_p[i] = 6'd7; end
        exp_p[1] = 6'd9; exp_p[2] = 6'd20;
        check_frame("padtie", 3, 1'b0, 6'd0, 6'd7);

        // Backpressure: ack withheld, producer pulses ignored.
        for (int c = 0; c < 10; c++) begin
            s_valid = c[0]; s_score = 6'd60; s_pos = 6'd60; s_last = 1'b1;
            step();
            check("bp_valid", 384'(frame_valid), 384'd1);
            check("bp_score_bus", slot_score, pack_s());
            check("bp_pos_bus", slot_pos, pack_p());
            check("bp_count", 384'(frame_count), 384'd3);
        end
        s_valid = 1'b0; s_last = 1'b0;
        ack();

        // Reset mid-fill discards the partial frame.
        for (int i = 0; i < 20; i++) send(6'(i + 1), 6'(i), 1'b0);
        rst = 1'b1;
        step();
        check("midrst_score_bus", slot_score, 384'd0);
        check("midrst_pos_bus", slot_pos, 384'd0);
        check("midrst_count", 384'(frame_count), 384'd0);
        check("midrst_valid", 384'(frame_valid), 384'd0);
        check("midrst_ready", 384'(s_ready), 384'd0);
        rst = 1'b0;
        #1;
        send(6'd3, 6'd4, 1'b0);
        send(6'd9, 6'd1, 1'b1);
        step();
        for (int i = 0; i < 64; i++) begin exp_s[i] = 6'd3; exp_p[i] = 6'd4; end
        exp_s[1] = 6'd9; exp_p[1] = 6'd1;
        check_frame("after_rst", 2, 1'b0, 6'd9, 6'd1);
        ack();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
